mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port data memory among N_REQ matrix-multiplication cores. These are the cores enabled by the en0..en3/enall control path.
- Each core's load/store path raises a request. The arbiter serialises the requests onto the memory port, handles read latency, and returns an ack with read data.
- Sits between the core datapaths and the data RAM, at top level beside the control units.

---
 rtl/mmul_pkg.sv | 24 ++
 rtl/rr_priority_select.sv | 31 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// mmul_pkg: shared types and defaults for the matrix-multiply cluster.
// Arbiter state encoding, default widths and an index-width helper.
package mmul_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Index width for n items; never below 1 so a port always exists.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin pick of the first set
// req bit at or after ptr (mod N). Ports: req, ptr in; found, idx out.
module rr_priority_select
  import mmul_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    // Farthest slot first, so the one nearest ptr overwrites last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one data-RAM port among N_REQ
// cores. In: req/we/addr/wdata per core, mem_rdata. Out: ack, rdata,
// mem_en/mem_we/mem_addr/mem_wdata, busy, grant_id. All outputs are
// registered; one access in flight at a time.
module mem_port_arbiter
  import mmul_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int READ_LAT = 1,
  localparam int IW       = clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic [IW-1:0]           grant_id
);

  localparam logic [2:0]    LAT_INIT = 3'(READ_LAT - 1);
  localparam logic [IW-1:0] LAST     = IW'(N_REQ - 1);

  arb_state_t state, state_nx;

  logic [IW-1:0]     rr_ptr, rr_nx;
  logic [2:0]        lat_cnt, lat_nx;
  logic [IW-1:0]     g, g_nx, g_inc;
  logic              l_we, l_we_nx;
  logic [N_REQ-1:0]  ack_nx;
  logic [DATA_W-1:0] rdata_nx;
  logic              en_nx, mwe_nx, busy_nx;
  logic [ADDR_W-1:0] maddr_nx;
  logic [DATA_W-1:0] mwd_nx;
  logic [IW-1:0]     gid_nx;

  logic              found;
  logic [IW-1:0]     sel;

  logic [ADDR_W-1:0] addr_a  [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  rr_priority_select #(
    .N  (N_REQ),
    .IW (IW)
  ) u_sel (
    .req   (req),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (sel)
  );

  assign g_inc = (g == LAST) ? '0 : g + 1'b1;

  // Outputs are computed for the state being entered and then
  // registered, so ISSUE-cycle strobes and acks appear on time.
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    lat_nx   = lat_cnt;
    g_nx     = g;
    l_we_nx  = l_we;
    ack_nx   = '0;
    rdata_nx = rdata;
    en_nx    = 1'b0;
    mwe_nx   = 1'b0;
    maddr_nx = mem_addr;
    mwd_nx   = mem_wdata;
    gid_nx   = grant_id;
    unique case (state)
      IDLE: begin
        if (found) begin
          g_nx        = sel;
          l_we_nx     = we[sel];
          gid_nx      = sel;
          en_nx       = 1'b1;
          mwe_nx      = we[sel];
          maddr_nx    = addr_a[sel];
          mwd_nx      = wdata_a[sel];
          ack_nx[sel] = we[sel];
          state_nx    = ISSUE;
        end
      end
      ISSUE: begin
        if (l_we) begin
          rr_nx    = g_inc;
          state_nx = IDLE;
        end else if (READ_LAT > 1) begin
          lat_nx   = LAT_INIT;
          state_nx = WAIT;
        end else begin
          rdata_nx  = mem_rdata;
          ack_nx[g] = 1'b1;
          state_nx  = RESP;
        end
      end
      WAIT: begin
        lat_nx = lat_cnt - 3'd1;
        if (lat_cnt <= 3'd1) begin
          lat_nx    = '0;
          rdata_nx  = mem_rdata;
          ack_nx[g] = 1'b1;
          state_nx  = RESP;
        end
      end
      RESP: begin
        rr_nx    = g_inc;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lat_cnt   <= '0;
      g         <= '0;
      l_we      <= 1'b0;
      ack       <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      lat_cnt   <= lat_nx;
      g         <= g_nx;
      l_we      <= l_we_nx;
      ack       <= ack_nx;
      rdata     <= rdata_nx;
      mem_en    <= en_nx;
      mem_we    <= mwe_nx;
      mem_addr  <= maddr_nx;
      mem_wdata <= mwd_nx;
      busy      <= busy_nx;
      grant_id  <= gid_nx;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random request traffic against a
// transaction-level model of grant order, timing and memory contents.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  ack;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    grant_id;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .N_REQ    (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (RL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return (i == 32) ? 8'h3C : 8'(i * 37 + 11);
  endfunction

  // Synchronous RAM, one output register: data valid for exactly one
  // cycle after the read strobe, junk otherwise.
  logic [7:0] ram [256];
  logic [7:0] rd_q, junk;
  logic       rd_v;
  bit         ram_ready;

  always @(posedge clk) begin
    junk <= 8'($urandom);
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
      rd_v      <= 1'b0;
    end else begin
      rd_v <= mem_en && !mem_we;
      if (mem_en && !mem_we) rd_q <= ram[mem_addr];
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = rd_v ? rd_q : junk;

  // Reference model state
  int         k = 0;
  int         ptr = 0;
  int         idle_edge = 0;
  int         t_iss = 0;
  int         t_ack = 0;
  int         cur_g = 0;
  int         gid_exp = 0;
  logic       cur_v = 1'b0;
  logic       cur_we = 1'b0;
  logic [7:0] cur_addr = '0;
  logic [7:0] cur_wd = '0;
  logic [7:0] rd_pend = '0;
  logic [7:0] rd_exp = '0;
  logic [7:0] ref_mem [256];

  // Core agents
  logic       act   [N];
  logic       a_we  [N];
  logic [7:0] a_addr[N];
  logic [7:0] a_wd  [N];
  int         cool  [N];
  int         mode  [N];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               tag, got, exp, k);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i] = act[i];
      if (act[i]) begin
        we[i]             = a_we[i];
        addr[i*AW +: AW]  = a_addr[i];
        wdata[i*DW +: DW] = a_wd[i];
      end else begin
        we[i]             = 1'($urandom);
        addr[i*AW +: AW]  = 8'($urandom);
        wdata[i*DW +: DW] = 8'($urandom);
      end
    end
  endtask

  task automatic start(input int i, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    act[i]    = 1'b1;
    a_we[i]   = w;
    a_addr[i] = a;
    a_wd[i]   = d;
    drive();
  endtask

  function automatic bit any_act();
    bit r;
    r = 0;
    for (int i = 0; i < N; i++) if (act[i]) r = 1;
    return r;
  endfunction

  task automatic step();
    logic          d_rst;
    logic [N-1:0]  d_req, d_we, e_ack;
    logic [N*AW-1:0] d_addr;
    logic [N*DW-1:0] d_wd;
    logic          e_en, e_busy;
    int            g, p;
    d_rst  = rst_n;
    d_req  = req;
    d_we   = we;
    d_addr = addr;
    d_wd   = wdata;
    @(posedge clk);
    #1;
    k++;
    if (!d_rst) begin
      ptr       = 0;
      idle_edge = k + 1;
      cur_v     = 1'b0;
      rd_exp    = '0;
      gid_exp   = 0;
    end else if (k >= idle_edge) begin
      if (d_req != '0) begin
        g = -1;
        for (int o = 0; o < N; o++) begin
          p = (ptr + o) % N;
          if (g < 0 && d_req[2'(p)]) g = p;
        end
        cur_v     = 1'b1;
        cur_g     = g;
        cur_we    = d_we[2'(g)];
        cur_addr  = d_addr[g*AW +: AW];
        cur_wd    = d_wd[g*DW +: DW];
        t_iss     = k;
        t_ack     = cur_we ? k : k + RL;
        idle_edge = t_ack + 2;
        ptr       = (g + 1) % N;
        gid_exp   = g;
        if (cur_we) ref_mem[cur_addr] = cur_wd;
        else        rd_pend = ref_mem[cur_addr];
      end else begin
        idle_edge = k + 1;
      end
    end
    e_en   = cur_v && (k == t_iss);
    e_busy = cur_v && (k >= t_iss) && (k <= t_ack);
    e_ack  = '0;
    if (cur_v && k == t_ack) begin
      e_ack = 4'(1) << cur_g;
      if (!cur_we) rd_exp = rd_pend;
    end
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("grant_id", 32'(grant_id), 32'(gid_exp));
    chk("rdata", 32'(rdata), 32'(rd_exp));
    if (e_en) begin
      chk("mem_we", 32'(mem_we), 32'(cur_we));
      chk("mem_addr", 32'(mem_addr), 32'(cur_addr));
      if (cur_we) chk("mem_wdata", 32'(mem_wdata), 32'(cur_wd));
    end
    if (!d_rst) begin
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin
        act[i]  = 1'b0;
        cool[i] = (mode[i] == 2) ? 1 : int'($urandom_range(1, 5));
      end else if (!act[i] && mode[i] != 0) begin
        if (cool[i] > 0) cool[i]--;
        if (cool[i] == 0)
          start(i, (mode[i] == 2) ? 1'b1 : 1'($urandom),
                8'($urandom_range(0, 15)), 8'($urandom));
      end
    end
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((any_act() || (cur_v && k <= t_ack)) && n < 200) begin
      step();
      n++;
    end
    step();
    chk("drain_timeout", 32'(n >= 200), 32'(0));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < N; i++) begin
      act[i]    = 1'b0;
      a_we[i]   = 1'b0;
      a_addr[i] = '0;
      a_wd[i]   = '0;
      cool[i]   = 0;
      mode[i]   = 0;
    end
    rst_n = 1'b0;
    drive();
    reset_pulse();

    // lone write from core 2
    start(2, 1'b1, 8'h10, 8'hA5);
    drain();

    // lone read from core 0, RAM preloaded with 0x3C
    start(0, 1'b0, 8'h20, 8'h00);
    drain();

    // all four write at once straight out of reset
    reset_pulse();
    start(0, 1'b1, 8'h01, 8'h11);
    start(1, 1'b1, 8'h02, 8'h22);
    start(2, 1'b1, 8'h03, 8'h33);
    start(3, 1'b1, 8'h04, 8'h44);
    drain();

    // core 1 keeps requesting, core 3 asks once
    mode[1] = 2;
    start(1, 1'b1, 8'h05, 8'h66);
    step();
    start(3, 1'b1, 8'h30, 8'h77);
    repeat (10) step();
    mode[1] = 0;
    drain();

    // reset lands while a read sits in WAIT
    start(0, 1'b0, 8'h20, 8'h00);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    start(3, 1'b1, 8'h40, 8'h99);
    start(1, 1'b1, 8'h41, 8'h98);
    drain();

    // write then read back through another core
    start(0, 1'b1, 8'h07, 8'h55);
    drain();
    start(3, 1'b0, 8'h07, 8'h00);
    drain();

    // random traffic from every core
    for (int i = 0; i < N; i++) begin
      mode[i] = 1;
      cool[i] = int'($urandom_range(0, 3));
    end
    repeat (600) step();
    for (int i = 0; i < N; i++) mode[i] = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
